// File: rtl/sn18x_pkg.sv
// rtl/sn18x_pkg.sv - shared types and constants for the SN18x BCD converter family
package sn18x_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int BCD_DIGIT_W = 4;

  // Double-dabble adjust: a digit of 5 or more gets 3 added before the shift
  localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  // Disabled parts drive every output digit to all ones
  localparam logic [BCD_DIGIT_W-1:0] DISABLED_DIGIT = '1;

endpackage

// File: rtl/dabble_digit.sv
// rtl/dabble_digit.sv - combinational shift-add-3 adjust cell for one BCD digit
module dabble_digit
  import sn18x_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // 4-bit add with no carry out; a legal digit (0-9) never wraps
  assign dout = (din >= ADJ_THRESH) ? din + ADJ_ADD : din;

endmodule

// File: rtl/sn185_seq_bin2bcd.sv
// rtl/sn185_seq_bin2bcd.sv - sequential binary-to-BCD converter, one bit per clock
module sn185_seq_bin2bcd
  import sn18x_pkg::*;
#(
  parameter int BIN_W  = 6,
  parameter int DIGITS = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            g_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [BIN_W-1:0]                bin_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_out,
  output logic                            ovf
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   sreg;
  logic [BCD_W-1:0]   digits;
  logic [BCD_W-1:0]   adj;
  logic               ovf_r;

  // {carry out of top digit, adjusted digits, shift register} after one left shift
  logic [BCD_W+BIN_W:0] shifted;

  // One adjust cell per digit; all digits are corrected in parallel before the shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    dabble_digit u_adj (
      .din  (digits[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign shifted = {adj, sreg, 1'b0};

  // Enable gates the handshakes and the digit output without waiting for a clock
  assign in_ready  = ~g_n & (state == IDLE);
  assign out_valid = ~g_n & (state == DONE);
  assign bcd_out   = g_n ? {DIGITS{DISABLED_DIGIT}} : digits;
  assign ovf       = ovf_r;

  // Conversion FSM: capture in IDLE, shift-add-3 BIN_W times, hold result in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      sreg   <= '0;
      digits <= '0;
      ovf_r  <= 1'b0;
    end else if (g_n) begin
      // Disable aborts whatever is in flight and discards the result
      state  <= IDLE;
      cnt    <= '0;
      sreg   <= '0;
      digits <= '0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sreg   <= bin_in;
            digits <= '0;
            ovf_r  <= 1'b0;
            cnt    <= CNT_LOAD;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          digits <= shifted[BCD_W+BIN_W-1:BIN_W];
          sreg   <= shifted[BIN_W-1:0];
          if (shifted[BCD_W+BIN_W]) begin
            ovf_r <= 1'b1;
          end
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sn185_seq_bin2bcd.sv
// tb/tb_sn185_seq_bin2bcd.sv - self-checking bench for sn185_seq_bin2bcd
module tb_sn185_seq_bin2bcd;

  localparam int BW = 6;
  localparam int D0 = 2;
  localparam int D1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Two-digit instance
  logic            g_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [BW-1:0]   bin_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [4*D0-1:0] bcd_out;
  logic            ovf;

  // One-digit instance for overflow behaviour
  logic            g_n_1 = 1'b0;
  logic            in_valid_1 = 1'b0;
  logic            in_ready_1;
  logic [BW-1:0]   bin_in_1 = '0;
  logic            out_valid_1;
  logic            out_ready_1 = 1'b0;
  logic [4*D1-1:0] bcd_out_1;
  logic            ovf_1;

  int tests = 0;
  int fails = 0;

  sn185_seq_bin2bcd #(.BIN_W(BW), .DIGITS(D0)) dut (
    .clk(clk), .rst_n(rst_n), .g_n(g_n),
    .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .bcd_out(bcd_out), .ovf(ovf)
  );

  sn185_seq_bin2bcd #(.BIN_W(BW), .DIGITS(D1)) dut_1 (
    .clk(clk), .rst_n(rst_n), .g_n(g_n_1),
    .in_valid(in_valid_1), .in_ready(in_ready_1), .bin_in(bin_in_1),
    .out_valid(out_valid_1), .out_ready(out_ready_1),
    .bcd_out(bcd_out_1), .ovf(ovf_1)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits of v by division, low digit in the low nibble
  function automatic logic [4*D0-1:0] ref_bcd0(input int v);
    logic [4*D0-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < D0; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf0(input int v);
    return (v > 99);
  endfunction

  function automatic logic [3:0] ref_bcd1(input int v);
    return 4'(v % 10);
  endfunction

  function automatic logic ref_ovf1(input int v);
    return (v > 9);
  endfunction

  task automatic accept0(input int v, output logic rdy);
    @(negedge clk);
    bin_in = BW'(v);
    in_valid = 1'b1;
    rdy = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out0(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 40);
    if (!out_valid) lat = -1;
  endtask

  task automatic consume0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic accept1(input int v, output logic rdy);
    @(negedge clk);
    bin_in_1 = BW'(v);
    in_valid_1 = 1'b1;
    rdy = in_ready_1;
    @(posedge clk);
    #1;
    in_valid_1 = 1'b0;
  endtask

  task automatic wait_out1(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid_1 && lat < 40);
    if (!out_valid_1) lat = -1;
  endtask

  task automatic consume1;
    out_ready_1 = 1'b1;
    @(posedge clk);
    #1;
    out_ready_1 = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    tests++;
    if ({in_ready, out_valid, bcd_out, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b ov=%b bcd=%h ovf=%b expected 1 0 00 0", in_ready, out_valid, bcd_out, ovf);
    end
    tests++;
    if ({in_ready_1, out_valid_1, bcd_out_1, ovf_1} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state_1: got rdy=%b ov=%b bcd=%h ovf=%b expected 1 0 0 0", in_ready_1, out_valid_1, bcd_out_1, ovf_1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic rdy;
    int lat;
    accept0(63, rdy);
    tests++;
    if (rdy !== 1'b1) begin
      fails++;
      $display("FAIL basic_ready: got %b expected 1", rdy);
    end
    wait_out0(lat);
    tests++;
    if (lat !== BW) begin
      fails++;
      $display("FAIL basic_latency: got %0d expected %0d", lat, BW);
    end
    tests++;
    if ({bcd_out, ovf} !== {8'h63, 1'b0}) begin
      fails++;
      $display("FAIL basic_result: got %h ovf=%b expected 63 ovf=0", bcd_out, ovf);
    end
    consume0();
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL basic_back_to_idle: got ov=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_values;
    int vals[$];
    logic rdy;
    int lat;
    vals = '{0, 10, 59, 1, 63};
    for (int i = 0; i < 12; i++) vals.push_back(int'($urandom_range(0, 63)));
    foreach (vals[i]) begin
      accept0(vals[i], rdy);
      tests++;
      if (rdy !== 1'b1) begin
        fails++;
        $display("FAIL values_ready v=%0d: got %b expected 1", vals[i], rdy);
      end
      wait_out0(lat);
      tests++;
      if (lat !== BW) begin
        fails++;
        $display("FAIL values_latency v=%0d: got %0d expected %0d", vals[i], lat, BW);
      end
      tests++;
      if ({bcd_out, ovf} !== {ref_bcd0(vals[i]), ref_ovf0(vals[i])}) begin
        fails++;
        $display("FAIL values_result v=%0d: got %h ovf=%b expected %h ovf=%b", vals[i], bcd_out, ovf, ref_bcd0(vals[i]), ref_ovf0(vals[i]));
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      consume0();
    end
  endtask

  task automatic test_backpressure;
    logic rdy;
    int lat;
    accept0(42, rdy);
    wait_out0(lat);
    tests++;
    if (lat !== BW) begin
      fails++;
      $display("FAIL bp_latency: got %0d expected %0d", lat, BW);
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      tests++;
      if ({out_valid, in_ready, bcd_out, ovf} !== {1'b1, 1'b0, 8'h42, 1'b0}) begin
        fails++;
        $display("FAIL bp_hold cycle %0d: got ov=%b rdy=%b bcd=%h ovf=%b expected 1 0 42 0", c, out_valid, in_ready, bcd_out, ovf);
      end
    end
    consume0();
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL bp_release: got ov=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_disable;
    logic rdy;
    int lat;
    accept0(51, rdy);
    @(posedge clk);
    @(posedge clk);
    #1;
    g_n = 1'b1;
    #1;
    tests++;
    if ({bcd_out, in_ready, out_valid} !== {8'hFF, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL disable_immediate: got bcd=%h rdy=%b ov=%b expected ff 0 0", bcd_out, in_ready, out_valid);
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      tests++;
      if ({out_valid, bcd_out} !== {1'b0, 8'hFF}) begin
        fails++;
        $display("FAIL disable_hold cycle %0d: got ov=%b bcd=%h expected 0 ff", c, out_valid, bcd_out);
      end
    end
    g_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, bcd_out, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL disable_reenable: got rdy=%b ov=%b bcd=%h ovf=%b expected 1 0 00 0", in_ready, out_valid, bcd_out, ovf);
    end
    accept0(7, rdy);
    wait_out0(lat);
    tests++;
    if ({lat, bcd_out, ovf} !== {BW, 8'h07, 1'b0}) begin
      fails++;
      $display("FAIL disable_next: got lat=%0d bcd=%h ovf=%b expected lat=%0d 07 0", lat, bcd_out, ovf, BW);
    end
    consume0();
  endtask

  task automatic test_async_reset;
    logic rdy;
    int lat;
    accept0(33, rdy);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, in_ready, bcd_out, ovf} !== {1'b0, 1'b1, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: got ov=%b rdy=%b bcd=%h ovf=%b expected 0 1 00 0", out_valid, in_ready, bcd_out, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL async_reset_no_result cycle %0d: got ov=%b expected 0", c, out_valid);
      end
    end
    accept0(45, rdy);
    wait_out0(lat);
    tests++;
    if ({lat, bcd_out, ovf} !== {BW, 8'h45, 1'b0}) begin
      fails++;
      $display("FAIL async_reset_next: got lat=%0d bcd=%h ovf=%b expected lat=%0d 45 0", lat, bcd_out, ovf, BW);
    end
    consume0();
  endtask

  task automatic test_back_to_back;
    int exp_q[$];
    int v;
    int last;
    int got;
    int lat;
    int e;
    logic accepted;
    last = -1;
    got = 0;
    @(negedge clk);
    v = int'($urandom_range(0, 63));
    bin_in = BW'(v);
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      accepted = 1'b0;
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL b2b_unexpected_output cycle %0d: got %h expected none", c, bcd_out);
        end else begin
          e = exp_q.pop_front();
          if (bcd_out !== ref_bcd0(e)) begin
            fails++;
            $display("FAIL b2b_result v=%0d: got %h expected %h", e, bcd_out, ref_bcd0(e));
          end
        end
        if (last >= 0) begin
          tests++;
          if (c - last !== BW + 2) begin
            fails++;
            $display("FAIL b2b_spacing: got %0d expected %0d", c - last, BW + 2);
          end
        end
        last = c;
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(v);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
      if (accepted) begin
        v = int'($urandom_range(0, 63));
        bin_in = BW'(v);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    tests++;
    if (got < 6) begin
      fails++;
      $display("FAIL b2b_count: got %0d expected at least 6", got);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      wait_out0(lat);
      tests++;
      if ({lat > 0, bcd_out} !== {1'b1, ref_bcd0(e)}) begin
        fails++;
        $display("FAIL b2b_drain v=%0d: got lat=%0d bcd=%h expected %h", e, lat, bcd_out, ref_bcd0(e));
      end
      consume0();
    end
  endtask

  task automatic test_ovf;
    int vals[$];
    logic rdy;
    int lat;
    vals = '{10, 9, 63, 0, 19};
    for (int i = 0; i < 8; i++) vals.push_back(int'($urandom_range(0, 63)));
    foreach (vals[i]) begin
      accept1(vals[i], rdy);
      wait_out1(lat);
      tests++;
      if ({rdy, lat} !== {1'b1, BW}) begin
        fails++;
        $display("FAIL ovf_handshake v=%0d: got rdy=%b lat=%0d expected 1 %0d", vals[i], rdy, lat, BW);
      end
      tests++;
      if ({bcd_out_1, ovf_1} !== {ref_bcd1(vals[i]), ref_ovf1(vals[i])}) begin
        fails++;
        $display("FAIL ovf_result v=%0d: got %h ovf=%b expected %h ovf=%b", vals[i], bcd_out_1, ovf_1, ref_bcd1(vals[i]), ref_ovf1(vals[i]));
      end
      consume1();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_backpressure();
    test_disable();
    test_async_reset();
    test_back_to_back();
    test_ovf();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sn185_seq_bin2bcd.md
Name: sn185_seq_bin2bcd

Overview:
Sequential binary-to-BCD converter: the reverse direction of the team's SN184-style BCD-to-binary converter. It accepts a BIN_W-bit unsigned binary value through a valid/ready handshake and converts it by shift-add-3 (double dabble), one bit per clock. It returns DIGITS packed BCD digits through a valid/ready handshake. It keeps the SN185 family's active-low enable, g_n.

Parameters:
BIN_W, 6, width of the binary input (≥1).
DIGITS, 2, number of BCD output digits (≥1); bcd_out width is 4*DIGITS.

Ports:
clk  input  1  clock, all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
g_n  input  1  active-low enable; high = disabled/abort.
in_valid  input  1  bin_in is valid.
in_ready  output  1  block can accept a new value.
bin_in  input  BIN_W  unsigned binary operand.
out_valid  output  1  bcd_out/ovf hold a completed result.
out_ready  input  1  consumer accepts the result.
bcd_out  output  4*DIGITS  packed BCD, digit 0 in bits [3:0].
ovf  output  1  the value exceeded 10^DIGITS-1 (result truncated).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; bit counter=0; shift register=0; digit registers=0; ovf=0; out_valid=0.
  - in_ready = ~g_n, so it is 1 after reset when g_n=0.
- Disable (g_n=1):
  - in_ready=0 and out_valid=0, combinationally.
  - bcd_out reads all ones, combinationally. This matches the family's disabled-output convention.
  - The FSM goes to IDLE at the next edge. Any conversion in flight is discarded; ovf and the digit registers are cleared.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. When in_valid&&in_ready at an edge: capture bin_in into the shift register, clear the digits and ovf, set counter=BIN_W, go to SHIFT. in_valid=0 keeps the FSM in IDLE.
  - SHIFT: in_ready=0, out_valid=0. Each edge:
    (a) every digit ≥5 gets +3 (4-bit, no carry);
    (b) shift the whole {digits, shift register} left by 1. The MSB of the shift register enters digit 0 bit 0. Each digit's bit 3 enters the next digit's bit 0.
    (c) a 1 shifted out of the top digit's bit 3 sets ovf (sticky);
    (d) counter decrements. When it reaches 0 after this edge, go to DONE.
  - DONE: out_valid=1; bcd_out and ovf are stable. When out_valid&&out_ready at an edge, go to IDLE. No new input is accepted in the same cycle: in_ready is asserted only in IDLE.
- Latency:
  - Accept at edge k; out_valid is high from edge k+BIN_W.
  - For BIN_W=6: 6 cycles. Minimum spacing between back-to-back transactions is BIN_W+2 cycles.
- Backpressure: out_ready=0 holds DONE indefinitely with the outputs unchanged.
- Overflow: with ovf=1, bcd_out holds the low DIGITS decimal digits of the value modulo 10^DIGITS. Example: DIGITS=1, value 10 → bcd_out=0, ovf=1. With BIN_W=6 and DIGITS=2, ovf never fires.
- Value outside BCD range never occurs: every digit output is 0-9.
- Reset mid-SHIFT or mid-DONE: immediate return to reset values; the result is lost, and no out_valid is produced.
- in_valid while not in IDLE is ignored (in_ready=0); the producer must hold its value.

Decomposition:
- Shared package sn18x_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - BCD_DIGIT_W=4;
  - ADJ_THRESH=5 and ADJ_ADD=3;
  - disabled-output constant (all ones).
- Sub-module dabble_digit: a combinational 4-bit adjust cell (in ≥5 → in+3). It is instantiated DIGITS times via generate.
- Counter width: $clog2(BIN_W+1).

Test Plan:
1. Reset, then g_n=0, bin_in=63, in_valid pulse → out_valid after 6 cycles; bcd_out=8'h63, ovf=0; out_ready=1 → IDLE, in_ready=1.
2. bin_in=0 → 8'h00. bin_in=10 → 8'h10. bin_in=59 → 8'h59. Each is delivered exactly 6 cycles after accept.
3. Result 8'h42 with out_ready held 0 for 20 cycles → out_valid and bcd_out stable and in_ready=0 throughout; accepted on out_ready=1.
4. g_n=1 on the third SHIFT cycle → bcd_out=8'hFF and in_ready=0 immediately, with no out_valid. Then g_n=0 and bin_in=7 → 8'h07.
5. rst_n low mid-SHIFT (asynchronous, between edges) → out_valid=0 and state IDLE at once. The next conversion of 45 → 8'h45.
6. DIGITS=1, bin_in=10 → bcd_out=4'h0, ovf=1. bin_in=9 → 4'h9, ovf=0.
